// File: rtl/lcd_bus_arbiter.sv
// Power-up/init sequencer and round-robin, burst-locking byte-write arbiter
// for an 8-bit HD44780-style character LCD.
//
// state   | meaning
// --------+-------------------------------------------------------------
// POWERUP | panel power-up delay before the first init command
// IDLE    | arbitrating client requests (busy=0)
// SETUP   | rs/dat driven, enable low
// PULSE   | enable high
// HOLD    | enable low, rs/dat held
// WAIT    | command execution wait (clear/home take longer)
module lcd_bus_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int DATA_BITS = 8,
  parameter int T_POWERUP = 750000,
  parameter int T_SETUP   = 2,
  parameter int T_EN      = 24,
  parameter int T_HOLD    = 2,
  parameter int T_EXEC    = 2500,
  parameter int T_CLEAR   = 82000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_rs,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [2:0]                     grant_id,
  output logic                           init_done,
  output logic                           busy,
  output logic                           rs,
  output logic                           rw,
  output logic                           enable,
  output logic [DATA_BITS-1:0]           dat
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max2(max2(max2(T_POWERUP, T_SETUP), max2(T_EN, T_HOLD)),
                              max2(T_EXEC, T_CLEAR));
  localparam int CNT_W = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    S_POWERUP,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_load;
  logic                 cnt_tc;
  logic [2:0]           ptr;
  logic [2:0]           lock_id;
  logic                 lock_vld;
  logic [1:0]           init_idx;

  logic [7:0]           valid_pad;
  logic [7:0]           rs_pad;
  logic [7:0]           last_pad;
  logic [7:0]           ready_pad;
  logic [DATA_BITS-1:0] data_arr [8];

  logic                 gnt_any;
  logic [2:0]           gnt_idx;
  logic                 take;
  logic                 is_clear;
  logic                 init_last;

  function automatic logic [2:0] wrap_add(input logic [2:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[2:0];
  endfunction

  function automatic logic [DATA_BITS-1:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return DATA_BITS'(8'h38);
      2'd1:    return DATA_BITS'(8'h06);
      2'd2:    return DATA_BITS'(8'h0C);
      default: return DATA_BITS'(8'h01);
    endcase
  endfunction

  // Widen per-client inputs to the 8-client maximum so a 3-bit index is always legal.
  always_comb begin
    valid_pad = '0;
    rs_pad    = '0;
    last_pad  = '0;
    valid_pad[NUM_REQ-1:0] = req_valid;
    rs_pad[NUM_REQ-1:0]    = req_rs;
    last_pad[NUM_REQ-1:0]  = req_last;
    for (int i = 0; i < 8; i++) data_arr[i] = '0;
    for (int i = 0; i < NUM_REQ; i++) data_arr[i] = req_data[i*DATA_BITS +: DATA_BITS];
  end

  // Reverse scan so the lowest offset from ptr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (lock_vld) begin
      gnt_any = valid_pad[lock_id];
      gnt_idx = lock_id;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (valid_pad[wrap_add(ptr, k)]) begin
          gnt_any = 1'b1;
          gnt_idx = wrap_add(ptr, k);
        end
      end
    end
  end

  assign take      = (state == S_IDLE) && init_done && gnt_any;
  assign ready_pad = take ? (8'b1 << gnt_idx) : 8'b0;
  assign req_ready = ready_pad[NUM_REQ-1:0];
  assign busy      = (state != S_IDLE);
  assign rw        = 1'b0;
  assign cnt_tc    = (cnt == '0);
  assign is_clear  = !rs && ((dat == DATA_BITS'(1)) || (dat == DATA_BITS'(2)));
  assign init_last = (init_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_POWERUP;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_POWERUP: if (cnt_tc) state_nxt = S_SETUP;
      S_IDLE:    if (take)   state_nxt = S_SETUP;
      S_SETUP:   if (cnt_tc) state_nxt = S_PULSE;
      S_PULSE:   if (cnt_tc) state_nxt = S_HOLD;
      S_HOLD:    if (cnt_tc) state_nxt = S_WAIT;
      S_WAIT: begin
        if (cnt_tc) begin
          if (!init_done && !init_last) state_nxt = S_SETUP;
          else                          state_nxt = S_IDLE;
        end
      end
      default:   state_nxt = S_POWERUP;
    endcase
  end

  always_comb begin
    cnt_load = '0;
    case (state_nxt)
      S_POWERUP: cnt_load = CNT_W'(T_POWERUP - 1);
      S_SETUP:   cnt_load = CNT_W'(T_SETUP - 1);
      S_PULSE:   cnt_load = CNT_W'(T_EN - 1);
      S_HOLD:    cnt_load = CNT_W'(T_HOLD - 1);
      S_WAIT:    cnt_load = is_clear ? CNT_W'(T_CLEAR - 1) : CNT_W'(T_EXEC - 1);
      default:   cnt_load = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= CNT_W'(T_POWERUP - 1);
      ptr       <= '0;
      lock_vld  <= 1'b0;
      lock_id   <= '0;
      init_idx  <= '0;
      init_done <= 1'b0;
      grant_id  <= '0;
      rs        <= 1'b0;
      dat       <= '0;
      enable    <= 1'b0;
    end else begin
      enable <= (state_nxt == S_PULSE);

      if (state_nxt != state) cnt <= cnt_load;
      else if (!cnt_tc)       cnt <= cnt - CNT_W'(1);

      if ((state == S_POWERUP) && cnt_tc) begin
        rs       <= 1'b0;
        dat      <= init_byte(2'd0);
        init_idx <= 2'd0;
      end

      if (take) begin
        rs       <= rs_pad[gnt_idx];
        dat      <= data_arr[gnt_idx];
        grant_id <= gnt_idx;
        if (last_pad[gnt_idx]) begin
          lock_vld <= 1'b0;
          ptr      <= wrap_add(gnt_idx, 1);
        end else begin
          lock_vld <= 1'b1;
          lock_id  <= gnt_idx;
        end
      end

      if ((state == S_WAIT) && cnt_tc && !init_done) begin
        if (init_last) begin
          init_done <= 1'b1;
        end else begin
          init_idx <= init_idx + 2'd1;
          rs       <= 1'b0;
          dat      <= init_byte(init_idx + 2'd1);
        end
      end
    end
  end

endmodule
